// File: rtl/rot_quad_gen.sv
// Quadrature rotary-encoder emulator: turns "N detents CW/CCW" commands into Gray-coded A/B phases.
// Optional contact-bounce emulation on the changing line is enabled by defining ROT_BOUNCE_EN.
module rot_quad_gen #(
  parameter int PHASE_CYC  = 2700,
  parameter int CNT_W      = 8,
  parameter int BOUNCE_CYC = 16
) (
  input  logic             input_clk_27M,
  input  logic             input_RESET_gen,
  input  logic             input_cmd_valid,
  output logic             output_cmd_ready,
  input  logic             input_cmd_dir,
  input  logic [CNT_W-1:0] input_cmd_count,
  output logic             output_Rot_A,
  output logic             output_Rot_B,
  output logic             output_busy,
  output logic             output_done
);

  localparam int TW = $clog2(PHASE_CYC);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [1:0]       ab_q, ab_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             zero_pend_q, zero_pend_d;

  // (A,B) after update idx; the fourth update always lands back on the 11 detent level.
  function automatic logic [1:0] gray_ab(input logic dir, input logic [1:0] idx);
    logic [1:0] r;
    case (idx)
      2'd0:    r = dir ? 2'b01 : 2'b10;
      2'd1:    r = 2'b00;
      2'd2:    r = dir ? 2'b10 : 2'b01;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  // Handshake: a command transfers on a rising edge where input_cmd_valid and output_cmd_ready
  // are both high; ready is a registered copy of "state is IDLE", so valid may stay high during RUN.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    ab_d        = ab_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    zero_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (zero_pend_q) done_d = 1'b1;
        if (input_cmd_valid && ready_q) begin
          if (input_cmd_count != '0) begin
            state_d = S_RUN;
            dir_d   = input_cmd_dir;
            cnt_d   = input_cmd_count;
            idx_d   = 2'd0;
            tmr_d   = '0;
          end else begin
            zero_pend_d = 1'b1;
          end
        end
      end
      default: begin
        tmr_d = (tmr_q == TW'(PHASE_CYC - 1)) ? '0 : tmr_q + 1'b1;
        if (tmr_q == '0) begin
          if (cnt_q == '0) begin
            // Final full phase at 11 has elapsed.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ab_d   = gray_ab(dir_q, idx_q);
            busy_d = 1'b1;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) cnt_d = cnt_q - 1'b1;
          end
        end
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge input_clk_27M) begin
    if (input_RESET_gen) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      tmr_q       <= '0;
      ab_q        <= 2'b11;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      zero_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  assign output_cmd_ready = ready_q;
  assign output_busy      = busy_q;
  assign output_done      = done_q;

`ifdef ROT_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYC + 1);

  logic          upd;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bline_q, bline_d;  // 1: A is the chattering line, 0: B
  logic [1:0]    out_q, out_d;

  assign upd = (state_q == S_RUN) && (tmr_q == '0) && (cnt_q != '0);

  // Offset d after an update drives new_value ^ d[0] on the changed line until d reaches BOUNCE_CYC.
  always_comb begin
    bcnt_d  = bcnt_q;
    bline_d = bline_q;
    out_d   = ab_d;
    if (upd) begin
      bcnt_d  = BW'(1);
      bline_d = ab_d[1] ^ ab_q[1];
    end else if (bcnt_q != '0) begin
      if (bline_q) out_d[1] = ab_q[1] ^ bcnt_q[0];
      else         out_d[0] = ab_q[0] ^ bcnt_q[0];
      bcnt_d = (bcnt_q == BW'(BOUNCE_CYC)) ? '0 : bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge input_clk_27M) begin
    if (input_RESET_gen) begin
      bcnt_q  <= '0;
      bline_q <= 1'b0;
      out_q   <= 2'b11;
    end else begin
      bcnt_q  <= bcnt_d;
      bline_q <= bline_d;
      out_q   <= out_d;
    end
  end

  assign output_Rot_A = out_q[1];
  assign output_Rot_B = out_q[0];
`else
  assign output_Rot_A = ab_q[1];
  assign output_Rot_B = ab_q[0];
`endif

endmodule
